// File: rtl/axi4_slave_read_data.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// axi4_slave_read_data
//
// Purpose:
//   R-channel engine of an AXI4 slave. The address stage hands over a burst
//   descriptor with a one-cycle ar_transfer_occurred pulse. This block then
//   walks the burst one beat at a time:
//     FETCH : strobe a single-word read of the synchronous backing memory
//     LOAD  : the memory answers this cycle; register its data into rdata
//     DATA  : present the beat and hold it until the master accepts it
//   Each beat therefore costs at least three cycles. Beat addresses follow
//   the AXI FIXED / INCR / WRAP rules. WRAP with a length other than 2, 4, 8
//   or 16 beats, and the reserved burst type 2'b11, are both walked as INCR.
//
// Parameters:
//   ADDR_WIDTH  byte address width
//   DATA_WIDTH  R data width (power of two, >= 8)
//   ID_WIDTH    transaction ID width
//   MEM_DEPTH   number of DATA_WIDTH words in the backing memory
//
// Ports:
//   clk                   clock, rising edge
//   rst                   asynchronous active-high reset
//   ar_transfer_occurred  one-cycle pulse: latched_* below are valid
//   latched_araddr        burst start byte address
//   latched_arid          burst ID
//   latched_arlen         beats minus one
//   latched_arsize        log2 of bytes per beat
//   latched_arburst       00 FIXED, 01 INCR, 10 WRAP
//   rready                master accepts the current R beat
//   mem_rd_data           memory read data, valid the cycle after mem_rd_en
//   rvalid/rdata/rid/rresp/rlast  AXI4 R channel
//   mem_rd_en             memory read strobe (one cycle per beat)
//   mem_rd_addr           memory word index
//   rd_busy               high whenever a burst is in progress
//
// Build option:
//   AXI4_RD_SLVERR_EN  when defined, a beat whose full word index is at or
//                      beyond MEM_DEPTH is answered with SLVERR and zero data
//                      without touching the memory. When undefined, the word
//                      index is simply the low address bits (the memory
//                      aliases) and every beat is OKAY.
// -----------------------------------------------------------------------------
module axi4_slave_read_data #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int MEM_DEPTH  = 1024
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         ar_transfer_occurred,
    input  logic [ADDR_WIDTH-1:0]        latched_araddr,
    input  logic [ID_WIDTH-1:0]          latched_arid,
    input  logic [7:0]                   latched_arlen,
    input  logic [2:0]                   latched_arsize,
    input  logic [1:0]                   latched_arburst,
    input  logic                         rready,
    input  logic [DATA_WIDTH-1:0]        mem_rd_data,
    output logic                         rvalid,
    output logic [DATA_WIDTH-1:0]        rdata,
    output logic [ID_WIDTH-1:0]          rid,
    output logic [1:0]                   rresp,
    output logic                         rlast,
    output logic                         mem_rd_en,
    output logic [$clog2(MEM_DEPTH)-1:0] mem_rd_addr,
    output logic                         rd_busy
);

    // -------------------------------------------------------------------------
    // Constants
    // -------------------------------------------------------------------------
    localparam int MEM_AW   = $clog2(MEM_DEPTH);
    // Byte-offset bits inside one data word; dropped to form the word index.
    localparam int ADDR_LSB = $clog2(DATA_WIDTH / 8);

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        LOAD,
        DATA
    } state_e;

    // -------------------------------------------------------------------------
    // State and captured burst descriptor
    // -------------------------------------------------------------------------
    state_e                  state_q;
    state_e                  state_d;

    logic [ADDR_WIDTH-1:0]   addr_q;      // byte address of the current beat
    logic [ID_WIDTH-1:0]     id_q;
    logic [7:0]              len_q;
    logic [2:0]              size_q;
    logic [1:0]              burst_q;
    logic [7:0]              beat_cnt_q;  // beats already accepted by master

    logic                    beat_done;   // R handshake this cycle
    logic                    out_of_range;

    assign beat_done = (state_q == DATA) && rvalid && rready;
    assign rid       = id_q;

    // -------------------------------------------------------------------------
    // Beat address arithmetic
    // -------------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0]   step;        // bytes per beat
    logic [ADDR_WIDTH-1:0]   wrap_mask;   // wrap container size minus one
    logic [ADDR_WIDTH-1:0]   incr_addr;
    logic                    wrap_legal;
    logic [ADDR_WIDTH-1:0]   next_addr;

    // NOTE: every signal written in an always_comb gets a default at the top of
    // the block, so no path through the case/if tree can leave it unassigned
    // and imply a latch.
    always_comb begin
        step       = ADDR_WIDTH'(1) << size_q;
        incr_addr  = addr_q + step;
        // (len+1) is a power of two for the legal WRAP lengths, so the
        // container is too and "mod container" reduces to a mask.
        wrap_mask  = ((ADDR_WIDTH'(len_q) + ADDR_WIDTH'(1)) << size_q)
                     - ADDR_WIDTH'(1);
        wrap_legal = (burst_q == BURST_WRAP) &&
                     ((len_q == 8'd1) || (len_q == 8'd3) ||
                      (len_q == 8'd7) || (len_q == 8'd15));
        next_addr  = incr_addr;

        if (burst_q == BURST_FIXED) begin
            next_addr = addr_q;
        end else if (wrap_legal) begin
            // Aligned container base plus the wrapped offset; the offset is
            // below the container size, so OR is the same as addition.
            next_addr = (addr_q & ~wrap_mask) | (incr_addr & wrap_mask);
        end
    end

    // -------------------------------------------------------------------------
    // Memory word index and range check
    // -------------------------------------------------------------------------
    assign mem_rd_addr = addr_q[ADDR_LSB +: MEM_AW];

`ifdef AXI4_RD_SLVERR_EN
    logic [ADDR_WIDTH-1:0]   word_full;   // word index before truncation

    assign word_full    = addr_q >> ADDR_LSB;
    assign out_of_range = (word_full >= ADDR_WIDTH'(MEM_DEPTH));
`else
    // Without range checking the memory aliases on the low address bits.
    assign out_of_range = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    // NOTE: clocked blocks use non-blocking assignments only, so every register
    // samples the pre-edge value of every other register regardless of the
    // order the simulator evaluates the blocks in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state and decoded outputs
    // -------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        mem_rd_en = 1'b0;
        rd_busy   = 1'b1;

        unique case (state_q)
            IDLE: begin
                rd_busy = 1'b0;
                // Pulses arriving in any other state are simply not looked at.
                if (ar_transfer_occurred) begin
                    state_d = FETCH;
                end
            end

            FETCH: begin
                // An out-of-range beat is answered locally; the memory is
                // left alone.
                mem_rd_en = !out_of_range;
                state_d   = LOAD;
            end

            LOAD: begin
                state_d = DATA;
            end

            DATA: begin
                if (beat_done) begin
                    state_d = rlast ? IDLE : FETCH;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath: descriptor capture, beat walk and R-channel registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q     <= '0;
            id_q       <= '0;
            len_q      <= '0;
            size_q     <= '0;
            burst_q    <= '0;
            beat_cnt_q <= '0;
            rvalid     <= 1'b0;
            rdata      <= '0;
            rresp      <= RESP_OKAY;
            rlast      <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (ar_transfer_occurred) begin
                        addr_q     <= latched_araddr;
                        id_q       <= latched_arid;
                        len_q      <= latched_arlen;
                        size_q     <= latched_arsize;
                        burst_q    <= latched_arburst;
                        beat_cnt_q <= '0;
                    end
                end

                FETCH: begin
                    // Address is held; the memory is reading it this cycle.
                end

                LOAD: begin
                    // mem_rd_data belongs to the read strobed in FETCH.
                    rvalid <= 1'b1;
                    rdata  <= out_of_range ? '0 : mem_rd_data;
                    rresp  <= out_of_range ? RESP_SLVERR : RESP_OKAY;
                    rlast  <= (beat_cnt_q == len_q);
                end

                DATA: begin
                    // rdata/rresp are left alone after the handshake; they are
                    // only meaningful while rvalid is high.
                    if (beat_done) begin
                        rvalid <= 1'b0;
                        rlast  <= 1'b0;
                        if (!rlast) begin
                            beat_cnt_q <= beat_cnt_q + 8'd1;
                            addr_q     <= next_addr;
                        end
                    end
                end

                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_slave_read_data.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_axi4_slave_read_data
//
// Self-checking bench for axi4_slave_read_data. A synchronous memory model
// answers mem_rd_en one cycle later (and returns noise otherwise) and records
// every word index strobed. Expected beats come from a burst-address model
// written directly from the AXI FIXED/INCR/WRAP arithmetic, plus the memory
// contents. Build with +define+AXI4_RD_SLVERR_EN to check the SLVERR variant.
// -----------------------------------------------------------------------------
module tb_axi4_slave_read_data;

    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;
    localparam int ID_WIDTH   = 4;
    localparam int MEM_DEPTH  = 1024;
    localparam int MEM_AW     = $clog2(MEM_DEPTH);
    localparam int BYTES      = DATA_WIDTH / 8;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    ar_transfer_occurred;
    logic [ADDR_WIDTH-1:0]   latched_araddr;
    logic [ID_WIDTH-1:0]     latched_arid;
    logic [7:0]              latched_arlen;
    logic [2:0]              latched_arsize;
    logic [1:0]              latched_arburst;
    logic                    rready;
    logic [DATA_WIDTH-1:0]   mem_rd_data;
    logic                    rvalid;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [ID_WIDTH-1:0]     rid;
    logic [1:0]              rresp;
    logic                    rlast;
    logic                    mem_rd_en;
    logic [MEM_AW-1:0]       mem_rd_addr;
    logic                    rd_busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    axi4_slave_read_data #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .ID_WIDTH   (ID_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .ar_transfer_occurred (ar_transfer_occurred),
        .latched_araddr       (latched_araddr),
        .latched_arid         (latched_arid),
        .latched_arlen        (latched_arlen),
        .latched_arsize       (latched_arsize),
        .latched_arburst      (latched_arburst),
        .rready               (rready),
        .mem_rd_data          (mem_rd_data),
        .rvalid               (rvalid),
        .rdata                (rdata),
        .rid                  (rid),
        .rresp                (rresp),
        .rlast                (rlast),
        .mem_rd_en            (mem_rd_en),
        .mem_rd_addr          (mem_rd_addr),
        .rd_busy              (rd_busy)
    );

    // -------------------------------------------------------------------------
    // Memory model and read-strobe monitor
    // -------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];
    logic [MEM_AW-1:0]       fetch_q[$];    // strobes since the last beat
    logic [MEM_AW-1:0]       fetch_log[$];  // strobes of the current test

    always @(posedge clk) begin
        if (mem_rd_en === 1'b1) begin
            mem_rd_data <= mem[mem_rd_addr];
            fetch_q.push_back(mem_rd_addr);
        end else begin
            mem_rd_data <= DATA_WIDTH'($urandom);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "watchdog expired");
    end

    // -------------------------------------------------------------------------
    // Reference model
    // -------------------------------------------------------------------------
    function automatic logic [ADDR_WIDTH-1:0] model_next(
        input logic [ADDR_WIDTH-1:0] a,
        input logic [7:0]            len,
        input logic [2:0]            size,
        input logic [1:0]            burst
    );
        longint unsigned step;
        longint unsigned container;
        longint unsigned base;
        longint unsigned off;
        step = 64'd1 << size;
        if (burst == 2'b00) return a;
        if (burst == 2'b10 && (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15)) begin
            container = (64'(len) + 64'd1) * step;
            base      = 64'(a) - (64'(a) % container);
            off       = (64'(a) + step) % container;
            return ADDR_WIDTH'(base + off);
        end
        return ADDR_WIDTH'(64'(a) + step);
    endfunction

    function automatic bit log_matches(input logic [MEM_AW-1:0] want[$]);
        bit ok;
        ok = (fetch_log.size() == want.size());
        foreach (want[i]) if (ok && fetch_log[i] !== want[i]) ok = 1'b0;
        return ok;
    endfunction

    function automatic string log_str();
        string s;
        s = "";
        foreach (fetch_log[i]) s = {s, $sformatf("%0d ", fetch_log[i])};
        return s;
    endfunction

    task automatic scramble_latched();
        latched_araddr  = $urandom;
        latched_arid    = ID_WIDTH'($urandom);
        latched_arlen   = 8'($urandom);
        latched_arsize  = 3'($urandom);
        latched_arburst = 2'($urandom);
    endtask

    // -------------------------------------------------------------------------
    // Burst engine: issues one descriptor and checks every beat against the
    // model. Enters and leaves on a falling edge.
    // -------------------------------------------------------------------------
    task automatic run_burst(
        input logic [ADDR_WIDTH-1:0] addr,
        input logic [ID_WIDTH-1:0]   id,
        input logic [7:0]            len,
        input logic [2:0]            size,
        input logic [1:0]            burst,
        input int                    stall_lo,
        input int                    stall_hi,
        input bit                    inject_ar
    );
        logic [ADDR_WIDTH-1:0] a;
        logic [31:0]           word;
        logic [DATA_WIDTH-1:0] exp_data;
        logic [1:0]            exp_resp;
        logic                  exp_last;
        logic                  oor;
        int                    exp_fetches;
        int                    lat;
        int                    nst;

        a               = addr;
        latched_araddr  = addr;
        latched_arid    = id;
        latched_arlen   = len;
        latched_arsize  = size;
        latched_arburst = burst;
        ar_transfer_occurred = 1'b1;

        for (int b = 0; b <= int'(len); b++) begin
            fetch_q.delete();
            lat = 0;
            do begin
                @(negedge clk);
                lat++;
                ar_transfer_occurred = 1'b0;
                rready = 1'b0;
                scramble_latched();
            end while (rvalid !== 1'b1 && lat < 16);

            word = a / BYTES;
`ifdef AXI4_RD_SLVERR_EN
            oor = (word >= 32'(MEM_DEPTH));
`else
            oor = 1'b0;
`endif
            if (oor) begin
                exp_data    = '0;
                exp_resp    = 2'b10;
                exp_fetches = 0;
            end else begin
                exp_data    = mem[word % MEM_DEPTH];
                exp_resp    = 2'b00;
                exp_fetches = 1;
            end
            exp_last = (b == int'(len));

            checks++;
            if (lat != 3) begin
                errors++;
                $display("FAIL latency beat %0d addr %h: got %0d cycles, want 3", b, a, lat);
            end
            checks++;
            if (rdata !== exp_data) begin
                errors++;
                $display("FAIL rdata beat %0d addr %h: got %h, want %h", b, a, rdata, exp_data);
            end
            checks++;
            if (rid !== id) begin
                errors++;
                $display("FAIL rid beat %0d: got %0d, want %0d", b, rid, id);
            end
            checks++;
            if (rresp !== exp_resp) begin
                errors++;
                $display("FAIL rresp beat %0d addr %h: got %b, want %b", b, a, rresp, exp_resp);
            end
            checks++;
            if (rlast !== exp_last) begin
                errors++;
                $display("FAIL rlast beat %0d of len %0d: got %b, want %b", b, len, rlast, exp_last);
            end
            checks++;
            if (rd_busy !== 1'b1) begin
                errors++;
                $display("FAIL rd_busy beat %0d: got %b, want 1", b, rd_busy);
            end
            checks++;
            if (fetch_q.size() != exp_fetches) begin
                errors++;
                $display("FAIL fetch_count beat %0d addr %h: got %0d strobes, want %0d",
                         b, a, fetch_q.size(), exp_fetches);
            end
            if (exp_fetches == 1 && fetch_q.size() == 1) begin
                checks++;
                if (fetch_q[0] !== MEM_AW'(word % MEM_DEPTH)) begin
                    errors++;
                    $display("FAIL fetch_index beat %0d: got %0d, want %0d",
                             b, fetch_q[0], word % MEM_DEPTH);
                end
            end
            foreach (fetch_q[i]) fetch_log.push_back(fetch_q[i]);

            nst = int'($urandom_range(stall_hi, stall_lo));
            if (inject_ar && b == 0) begin
                if (nst == 0) nst = 1;
                scramble_latched();
                ar_transfer_occurred = 1'b1;
            end
            for (int s = 0; s < nst; s++) begin
                @(negedge clk);
                ar_transfer_occurred = 1'b0;
                checks++;
                if ({rvalid, rdata, rid, rresp, rlast} !== {1'b1, exp_data, id, exp_resp, exp_last}) begin
                    errors++;
                    $display("FAIL stall_hold beat %0d cycle %0d: got v%b d%h id%0d r%b l%b, want v1 d%h id%0d r%b l%b",
                             b, s, rvalid, rdata, rid, rresp, rlast, exp_data, id, exp_resp, exp_last);
                end
            end
            rready = 1'b1;
            a = model_next(a, len, size, burst);
        end

        @(negedge clk);
        rready = 1'b0;
        checks++;
        if ({rvalid, rlast, rd_busy} !== 3'b000) begin
            errors++;
            $display("FAIL burst_end: got rvalid %b rlast %b rd_busy %b, want 0 0 0", rvalid, rlast, rd_busy);
        end
        fetch_q.delete();
        repeat (4) @(negedge clk);
        checks++;
        if (fetch_q.size() != 0 || rvalid !== 1'b0) begin
            errors++;
            $display("FAIL idle_quiet: got %0d strobes rvalid %b after burst, want 0 strobes rvalid 0",
                     fetch_q.size(), rvalid);
        end
    endtask

    // -------------------------------------------------------------------------
    // Tests
    // -------------------------------------------------------------------------
    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({rvalid, rlast, mem_rd_en, rd_busy} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl: got rvalid %b rlast %b mem_rd_en %b rd_busy %b, want all 0",
                     rvalid, rlast, mem_rd_en, rd_busy);
        end
        checks++;
        if ({rdata, rid, rresp, mem_rd_addr} !== '0) begin
            errors++;
            $display("FAIL reset_data: got rdata %h rid %0d rresp %b mem_rd_addr %0d, want all 0",
                     rdata, rid, rresp, mem_rd_addr);
        end
        rst = 1'b0;
        fetch_q.delete();
        repeat (3) @(negedge clk);
        checks++;
        if (fetch_q.size() != 0 || rvalid !== 1'b0 || rd_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got %0d strobes rvalid %b rd_busy %b, want 0 0 0",
                     fetch_q.size(), rvalid, rd_busy);
        end
    endtask

    task automatic test_single_incr();
        mem[4] = 32'hA5A5_A5A5;
        fetch_log.delete();
        run_burst(32'h10, 4'd9, 8'd0, 3'd2, 2'b01, 0, 0, 1'b0);
        checks++;
        if (!log_matches('{10'd4})) begin
            errors++;
            $display("FAIL single_incr_index: got %s, want 4", log_str());
        end
    endtask

    task automatic test_incr_stall();
        fetch_log.delete();
        run_burst(32'h0, 4'd2, 8'd3, 3'd2, 2'b01, 2, 2, 1'b0);
        checks++;
        if (!log_matches('{10'd0, 10'd1, 10'd2, 10'd3})) begin
            errors++;
            $display("FAIL incr_stall_order: got %s, want 0 1 2 3", log_str());
        end
    endtask

    task automatic test_wrap();
        fetch_log.delete();
        run_burst(32'h38, 4'd7, 8'd3, 3'd2, 2'b10, 0, 1, 1'b0);
        checks++;
        if (!log_matches('{10'd14, 10'd15, 10'd12, 10'd13})) begin
            errors++;
            $display("FAIL wrap_order: got %s, want 14 15 12 13", log_str());
        end
    endtask

    task automatic test_fixed();
        fetch_log.delete();
        run_burst(32'h20, 4'd5, 8'd2, 3'd2, 2'b00, 0, 1, 1'b0);
        checks++;
        if (!log_matches('{10'd8, 10'd8, 10'd8})) begin
            errors++;
            $display("FAIL fixed_order: got %s, want 8 8 8", log_str());
        end
    endtask

    task automatic test_ignored_ar();
        fetch_log.delete();
        run_burst(32'h200, 4'd11, 8'd3, 3'd2, 2'b01, 1, 2, 1'b1);
        checks++;
        if (!log_matches('{10'd128, 10'd129, 10'd130, 10'd131})) begin
            errors++;
            $display("FAIL ignored_ar_order: got %s, want 128 129 130 131", log_str());
        end
    endtask

    task automatic test_out_of_range();
        fetch_log.delete();
        run_burst(32'hFFC, 4'd1, 8'd1, 3'd2, 2'b01, 0, 1, 1'b0);
        checks++;
`ifdef AXI4_RD_SLVERR_EN
        if (!log_matches('{10'd1023})) begin
            errors++;
            $display("FAIL range_strobes: got %s, want 1023", log_str());
        end
`else
        if (!log_matches('{10'd1023, 10'd0})) begin
            errors++;
            $display("FAIL range_strobes: got %s, want 1023 0", log_str());
        end
`endif
    endtask

    task automatic test_reset_mid_burst();
        int lat;
        int seen;
        latched_araddr  = 32'h100;
        latched_arid    = 4'd3;
        latched_arlen   = 8'd7;
        latched_arsize  = 3'd2;
        latched_arburst = 2'b01;
        ar_transfer_occurred = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            ar_transfer_occurred = 1'b0;
        end while (rvalid !== 1'b1 && lat < 16);
        rready = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            rready = 1'b0;
        end while (rvalid !== 1'b1 && lat < 16);
        checks++;
        if (rvalid !== 1'b1 || rdata !== mem[65]) begin
            errors++;
            $display("FAIL reset_setup: got rvalid %b rdata %h on beat 2, want 1 %h", rvalid, rdata, mem[65]);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({rvalid, rd_busy, rlast, mem_rd_en} !== 4'b0000 || rdata !== '0) begin
            errors++;
            $display("FAIL reset_async: got rvalid %b rd_busy %b rlast %b mem_rd_en %b rdata %h, want 0 0 0 0 0",
                     rvalid, rd_busy, rlast, mem_rd_en, rdata);
        end
        @(negedge clk);
        rst = 1'b0;
        rready = 1'b1;
        fetch_q.delete();
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (rvalid === 1'b1 || rd_busy === 1'b1) seen++;
        end
        rready = 1'b0;
        checks++;
        if (seen != 0 || fetch_q.size() != 0) begin
            errors++;
            $display("FAIL reset_abandon: got %0d busy cycles %0d strobes after reset, want 0 0",
                     seen, fetch_q.size());
        end
        run_burst(32'h40, 4'd6, 8'd1, 3'd2, 2'b01, 0, 1, 1'b0);
    endtask

    task automatic test_random();
        logic [7:0] len_tab [5];
        logic [7:0] len;
        len_tab = '{8'd0, 8'd1, 8'd3, 8'd7, 8'd15};
        for (int n = 0; n < 25; n++) begin
            if ($urandom_range(2, 0) != 0) len = len_tab[$urandom_range(4, 0)];
            else len = 8'($urandom_range(10, 0));
            run_burst(ADDR_WIDTH'($urandom_range(32'h1FFF, 0)), ID_WIDTH'($urandom), len,
                      3'($urandom_range(2, 0)), 2'($urandom_range(3, 0)),
                      0, 2, 1'($urandom));
        end
    endtask

    // -------------------------------------------------------------------------
    // Sequencer
    // -------------------------------------------------------------------------
    initial begin
        rst                  = 1'b1;
        ar_transfer_occurred = 1'b0;
        latched_araddr       = '0;
        latched_arid         = '0;
        latched_arlen        = '0;
        latched_arsize       = '0;
        latched_arburst      = '0;
        rready               = 1'b0;
        foreach (mem[i]) mem[i] = DATA_WIDTH'($urandom);

        test_reset();
        test_single_incr();
        test_incr_stall();
        test_wrap();
        test_fixed();
        test_ignored_ar();
        test_out_of_range();
        test_reset_mid_burst();
        test_random();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
